// File: rtl/db_status_capture16_pkg.sv
// Shared constants for the daughterboard status-capture slice: register indices,
// line width and the ATR state encodings common with the control-line driver.
package db_status_capture16_pkg;

    localparam int unsigned DBSC_WIDTH = 32;

    localparam logic [3:0] DBSC_REG_PINS    = 4'd0;
    localparam logic [3:0] DBSC_REG_RISE_EN = 4'd1;
    localparam logic [3:0] DBSC_REG_FALL_EN = 4'd2;
    localparam logic [3:0] DBSC_REG_EVENTS  = 4'd3;
    localparam logic [3:0] DBSC_REG_SNAP    = 4'd4;

    typedef enum logic [1:0] {
        ATR_IDLE        = 2'd0,
        ATR_TX          = 2'd1,
        ATR_RX          = 2'd2,
        ATR_FULL_DUPLEX = 2'd3
    } atr_state_t;

    // Expands the two Wishbone byte selects into a 32-bit mask for the addressed half.
    function automatic logic [DBSC_WIDTH-1:0] dbsc_byte_mask(input logic hi, input logic [1:0] sel);
        logic [15:0] half;
        half = {{8{sel[1]}}, {8{sel[0]}}};
        return hi ? {half, 16'h0000} : {16'h0000, half};
    endfunction

endpackage

// File: rtl/db_sync_edge.sv
// Per-bit input conditioner: synchronizer chain, optional debounce counter
// (compiled in with DB_STATUS_CAPTURE_DEBOUNCE_EN) and rise/fall detection.
module db_sync_edge #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic pin_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   pin;
    logic                   prev_q;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= pin;
        end
    end

`ifdef DB_STATUS_CAPTURE_DEBOUNCE_EN
    logic [7:0] cnt_q, cnt_d;
    logic       pin_q, pin_d;

    // Counter counts consecutive cycles of disagreement; any agreement restarts it.
    always_comb begin
        cnt_d = '0;
        pin_d = pin_q;
        if (sync_out != pin_q) begin
            if (cnt_q == 8'(DEBOUNCE_CYCLES - 1)) begin
                pin_d = sync_out;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            pin_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pin_q <= pin_d;
        end
    end

    assign pin = pin_q;
`else
    localparam int unsigned unused_debounce = DEBOUNCE_CYCLES;
    assign pin = sync_out;
`endif

    assign pin_o  = pin;
    assign rise_o = pin & ~prev_q;
    assign fall_o = ~pin & prev_q;

endmodule

// File: rtl/db_status_capture16.sv
// Daughterboard status capture: 32 synchronized lines, masked sticky edge events,
// snapshot and level interrupt behind a 16-bit Wishbone slave. Optional debounce: DB_STATUS_CAPTURE_DEBOUNCE_EN.
module db_status_capture16 #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [5:0]  adr_i,
    input  logic [1:0]  sel_i,
    input  logic [15:0] dat_i,
    output logic [15:0] dat_o,
    input  logic        we_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic        ack_o,
    input  logic [31:0] db_in,
    output logic        int_o
);
    import db_status_capture16_pkg::*;

    logic [DBSC_WIDTH-1:0] pins, rise, fall;

    for (genvar i = 0; i < DBSC_WIDTH; i++) begin : g_bit
        db_sync_edge #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_sync_edge (
            .clk_i  (clk_i),
            .rst_n_i(rst_n_i),
            .d_i    (db_in[i]),
            .pin_o  (pins[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

    logic                  ack_q;
    logic [15:0]           dat_q, dat_d;
    logic [DBSC_WIDTH-1:0] rise_en_q, rise_en_d;
    logic [DBSC_WIDTH-1:0] fall_en_q, fall_en_d;
    logic [DBSC_WIDTH-1:0] events_q, events_d;
    logic [DBSC_WIDTH-1:0] snap_q, snap_d;
    logic                  snap_valid_q, snap_valid_d;
    logic                  int_q;

    logic                  access, wr;
    logic [3:0]            idx;
    logic [DBSC_WIDTH-1:0] bmask, wdata, clr, rdata32;
    logic                  unused_adr;

    assign unused_adr = adr_i[0];
    assign idx        = adr_i[5:2];
    assign access     = stb_i & cyc_i & ~ack_q;
    assign wr         = access & we_i;
    assign bmask      = dbsc_byte_mask(adr_i[1], sel_i);
    assign wdata      = {dat_i, dat_i};

    always_comb begin
        rdata32 = '0;
        case (idx)
            DBSC_REG_PINS:    rdata32 = pins;
            DBSC_REG_RISE_EN: rdata32 = rise_en_q;
            DBSC_REG_FALL_EN: rdata32 = fall_en_q;
            DBSC_REG_EVENTS:  rdata32 = events_q;
            DBSC_REG_SNAP:    rdata32 = snap_q;
            default:          rdata32 = '0;
        endcase
    end

    always_comb begin
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr       = '0;
        if (wr && idx == DBSC_REG_RISE_EN) rise_en_d = (rise_en_q & ~bmask) | (wdata & bmask);
        if (wr && idx == DBSC_REG_FALL_EN) fall_en_d = (fall_en_q & ~bmask) | (wdata & bmask);
        if (wr && idx == DBSC_REG_EVENTS)  clr = wdata & bmask;

        // Sets are OR-ed after the clear so a coincident edge survives the W1C.
        events_d = (events_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);

        // snap_valid_q mirrors "EVENTS nonzero"; the snapshot loads on the zero-to-nonzero step.
        snap_d       = snap_q;
        snap_valid_d = |events_d;
        if (!snap_valid_q && (|events_d)) snap_d = pins;

        dat_d = '0;
        if (access) dat_d = adr_i[1] ? rdata32[31:16] : rdata32[15:0];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_q        <= 1'b0;
            dat_q        <= '0;
            rise_en_q    <= '0;
            fall_en_q    <= '0;
            events_q     <= '0;
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
            int_q        <= 1'b0;
        end else begin
            ack_q        <= access;
            dat_q        <= dat_d;
            rise_en_q    <= rise_en_d;
            fall_en_q    <= fall_en_d;
            events_q     <= events_d;
            snap_q       <= snap_d;
            snap_valid_q <= snap_valid_d;
            int_q        <= |events_d;
        end
    end

    assign ack_o = ack_q;
    assign dat_o = dat_q;
    assign int_o = int_q;

endmodule

// File: tb/tb_db_status_capture16.sv
// Bench for db_status_capture16: directed test-plan cases plus randomized traffic
// against a behavioural model. Debounce cases build with DB_STATUS_CAPTURE_DEBOUNCE_EN.
module tb_db_status_capture16;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 8;
`ifdef DB_STATUS_CAPTURE_DEBOUNCE_EN
    localparam int unsigned LAT  = SYNC + DEB + 1;
`else
    localparam int unsigned LAT  = SYNC + 1;
`endif

    logic        clk_i   = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [5:0]  adr_i   = '0;
    logic [1:0]  sel_i   = '0;
    logic [15:0] dat_i   = '0;
    logic [15:0] dat_o;
    logic        we_i    = 1'b0;
    logic        stb_i   = 1'b0;
    logic        cyc_i   = 1'b0;
    logic        ack_o;
    logic [31:0] db_in   = '0;
    logic        int_o;

    int n_checks = 0;
    int n_fail   = 0;

    db_status_capture16 #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .adr_i  (adr_i),
        .sel_i  (sel_i),
        .dat_i  (dat_i),
        .dat_o  (dat_o),
        .we_i   (we_i),
        .stb_i  (stb_i),
        .cyc_i  (cyc_i),
        .ack_o  (ack_o),
        .db_in  (db_in),
        .int_o  (int_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: pins are the input delayed by the synchronizer depth
    // (and, with debounce, change only after a full run of disagreeing samples).
    logic [31:0] dq [$];
    logic [31:0] sh [$];
    logic [31:0] m_pins = '0, m_prev = '0, m_sync = '0;
    logic [31:0] m_ren = '0, m_fen = '0, m_ev = '0, m_snap = '0;
    logic        m_ack = 1'b0, m_int = 1'b0;
    logic [15:0] m_rd = '0;
    logic [31:0] t_bm, t_wd, t_full, t_nev, t_clr, t_np;
    logic        t_acc, t_hi, t_stable;
    logic [3:0]  t_idx;

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m_pins = '0; m_prev = '0; m_sync = '0;
            m_ren = '0; m_fen = '0; m_ev = '0; m_snap = '0;
            m_ack = 1'b0; m_int = 1'b0; m_rd = '0;
            dq.delete();
            sh.delete();
            for (int k = 0; k < int'(SYNC); k++) dq.push_back(32'h0);
        end else begin
            t_acc = stb_i && cyc_i && !m_ack;
            t_idx = adr_i[5:2];
            t_hi  = adr_i[1];
            t_bm  = '0;
            if (sel_i[1]) t_bm = t_bm | (t_hi ? 32'hFF00_0000 : 32'h0000_FF00);
            if (sel_i[0]) t_bm = t_bm | (t_hi ? 32'h00FF_0000 : 32'h0000_00FF);
            t_wd = {dat_i, dat_i};
            case (t_idx)
                4'd0:    t_full = m_pins;
                4'd1:    t_full = m_ren;
                4'd2:    t_full = m_fen;
                4'd3:    t_full = m_ev;
                4'd4:    t_full = m_snap;
                default: t_full = '0;
            endcase
            t_clr = (t_acc && we_i && t_idx == 4'd3) ? (t_wd & t_bm) : 32'h0;
            t_nev = (m_ev & ~t_clr) | (m_pins & ~m_prev & m_ren) | (~m_pins & m_prev & m_fen);
            if (m_ev == 32'h0 && t_nev != 32'h0) m_snap = m_pins;
            if (t_acc && we_i && t_idx == 4'd1) m_ren = (m_ren & ~t_bm) | (t_wd & t_bm);
            if (t_acc && we_i && t_idx == 4'd2) m_fen = (m_fen & ~t_bm) | (t_wd & t_bm);
            m_ev  = t_nev;
            m_int = (t_nev != 32'h0);
            m_rd  = t_acc ? (t_hi ? t_full[31:16] : t_full[15:0]) : 16'h0;
            m_ack = t_acc;

            dq.push_front(db_in);
            void'(dq.pop_back());
`ifdef DB_STATUS_CAPTURE_DEBOUNCE_EN
            sh.push_front(m_sync);
            if (sh.size() > int'(DEB)) void'(sh.pop_back());
            t_np = m_pins;
            if (sh.size() == int'(DEB)) begin
                for (int b = 0; b < 32; b++) begin
                    t_stable = 1'b1;
                    for (int j = 0; j < int'(DEB); j++)
                        if (sh[j][b] == m_pins[b]) t_stable = 1'b0;
                    if (t_stable) t_np[b] = ~m_pins[b];
                end
            end
            m_prev = m_pins;
            m_pins = t_np;
            m_sync = dq[SYNC-1];
`else
            m_prev = m_pins;
            m_pins = dq[SYNC-1];
`endif
        end
    end

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            check_eq("int_cycle", 32'(int_o), 32'(m_int));
            check_eq("ack_cycle", 32'(ack_o), 32'(m_ack));
        end
    end

    task automatic wb_access(input logic [5:0] adr, input logic [1:0] sel, input logic we,
                             input logic [15:0] wd, output logic [15:0] rd);
        adr_i = adr; sel_i = sel; we_i = we; dat_i = wd;
        stb_i = 1'b1; cyc_i = 1'b1;
        @(negedge clk_i);
        check_eq("ack_hi", 32'(ack_o), 32'd1);
        if (!we) check_eq("rd_model", 32'(dat_o), 32'(m_rd));
        rd = dat_o;
        stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0;
        @(negedge clk_i);
        check_eq("ack_lo", 32'(ack_o), 32'd0);
    endtask

    task automatic wb_write(input logic [5:0] adr, input logic [1:0] sel, input logic [15:0] wd);
        logic [15:0] unused_rd;
        wb_access(adr, sel, 1'b1, wd, unused_rd);
    endtask

    task automatic wb_read(input logic [5:0] adr, output logic [15:0] rd);
        wb_access(adr, 2'b11, 1'b0, 16'h0000, rd);
    endtask

    initial begin
        logic [15:0] rd;
        int unsigned op;
        logic        hi;
        logic [3:0]  idx;

        repeat (3) @(negedge clk_i);
        #2 rst_n_i = 1'b1;
        @(negedge clk_i);
        check_eq("rst_int", 32'(int_o), 32'd0);
        check_eq("rst_ack", 32'(ack_o), 32'd0);
        check_eq("rst_dat", 32'(dat_o), 32'd0);
        for (int r = 0; r < 16; r++)
            for (int h = 0; h < 2; h++) begin
                wb_read(6'(r * 4 + h * 2), rd);
                check_eq("rst_reg", 32'(rd), 32'd0);
            end

        // First masked rise: event latency and snapshot
        wb_write(6'h04, 2'b11, 16'h0001);
        db_in[0] = 1'b1;
        repeat (LAT - 1) @(negedge clk_i);
        check_eq("lat_before", 32'(int_o), 32'd0);
        @(negedge clk_i);
        check_eq("lat_at", 32'(int_o), 32'd1);
        wb_read(6'h0C, rd); check_eq("ev_lo_bit0", 32'(rd), 32'h0001);
        wb_read(6'h10, rd); check_eq("snap_lo", 32'(rd), 32'h0001);

        // Falling-only mask on bit 31
        wb_write(6'h0C, 2'b01, 16'h0001);
        wb_write(6'h04, 2'b11, 16'h0000);
        wb_write(6'h0A, 2'b11, 16'h8000);
        check_eq("int_cleared", 32'(int_o), 32'd0);
        db_in[31] = 1'b1;
        repeat (LAT + 2) @(negedge clk_i);
        wb_read(6'h0E, rd); check_eq("rise31_masked", 32'(rd), 32'h0000);
        db_in[31] = 1'b0;
        repeat (LAT + 2) @(negedge clk_i);
        wb_read(6'h0E, rd); check_eq("fall31_event", 32'(rd), 32'h8000);

        // W1C coinciding with a new masked rise on bit 0
        wb_write(6'h04, 2'b01, 16'h0001);
        db_in[0] = 1'b0;
        repeat (LAT + 2) @(negedge clk_i);
        db_in[0] = 1'b1;
        repeat (LAT - 1) @(negedge clk_i);
        wb_write(6'h0C, 2'b01, 16'h0001);
        wb_read(6'h0C, rd); check_eq("set_wins", 32'(rd), 32'h0001);

        // Byte-selective clear, interrupt drop, snapshot reload
        wb_write(6'h0E, 2'b10, 16'hFF00);
        wb_read(6'h0E, rd); check_eq("clr_hi_byte", 32'(rd), 32'h0000);
        wb_read(6'h0C, rd); check_eq("keep_lo", 32'(rd), 32'h0001);
        check_eq("int_still", 32'(int_o), 32'd1);
        wb_write(6'h0C, 2'b01, 16'h0001);
        check_eq("int_drop", 32'(int_o), 32'd0);
        db_in[5] = 1'b1;
        repeat (LAT + 2) @(negedge clk_i);
        db_in[31] = 1'b1;
        repeat (LAT + 2) @(negedge clk_i);
        db_in[31] = 1'b0;
        repeat (LAT + 2) @(negedge clk_i);
        wb_read(6'h0E, rd); check_eq("ev_hi_again", 32'(rd), 32'h8000);
        wb_read(6'h10, rd); check_eq("snap_reload_lo", 32'(rd), 32'h0021);
        wb_read(6'h12, rd); check_eq("snap_reload_hi", 32'(rd), 32'h0000);

        // Back-to-back strobes ack every other cycle
        adr_i = 6'h00; sel_i = 2'b11; we_i = 1'b0; stb_i = 1'b1; cyc_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            check_eq("b2b_ack", 32'(ack_o), (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        stb_i = 1'b0; cyc_i = 1'b0;
        @(negedge clk_i);

`ifdef DB_STATUS_CAPTURE_DEBOUNCE_EN
        wb_write(6'h0E, 2'b11, 16'hFFFF);
        wb_write(6'h0C, 2'b11, 16'hFFFF);
        wb_write(6'h04, 2'b11, 16'h0008);
        wb_write(6'h0A, 2'b11, 16'h0000);
        check_eq("deb_int_clr", 32'(int_o), 32'd0);
        db_in[3] = 1'b1;
        repeat (5) @(negedge clk_i);
        db_in[3] = 1'b0;
        repeat (30) @(negedge clk_i);
        check_eq("deb_glitch", 32'(int_o), 32'd0);
        db_in[3] = 1'b1;
        repeat (LAT - 1) @(negedge clk_i);
        check_eq("deb_before", 32'(int_o), 32'd0);
        @(negedge clk_i);
        check_eq("deb_at", 32'(int_o), 32'd1);
        repeat (20 - LAT) @(negedge clk_i);
        db_in[3] = 1'b0;
        repeat (LAT + 2) @(negedge clk_i);
        wb_read(6'h0C, rd); check_eq("deb_event", 32'(rd), 32'h0008);
`endif

        // Randomized traffic checked against the model
        for (int it = 0; it < 400; it++) begin
            op  = $urandom_range(0, 6);
            hi  = 1'($urandom_range(0, 1));
            case (op)
                0: begin
                    db_in = db_in ^ ($urandom & $urandom & $urandom);
                    repeat ($urandom_range(0, 4)) @(negedge clk_i);
                end
                1: wb_write({4'd1, hi, 1'b0}, 2'($urandom), 16'($urandom));
                2: wb_write({4'd2, hi, 1'b0}, 2'($urandom), 16'($urandom));
                3: wb_write({4'd3, hi, 1'b0}, 2'($urandom), 16'($urandom & $urandom));
                4, 5: begin
                    idx = 4'($urandom_range(0, 5));
                    wb_read({idx, hi, 1'b0}, rd);
                end
                default: begin
                    idx = 4'($urandom);
                    wb_write({idx, hi, 1'b0}, 2'($urandom), 16'($urandom));
                end
            endcase
        end

        // Reset during an access drops ack and clears state
        repeat (LAT + 2) @(negedge clk_i);
        wb_write(6'h04, 2'b11, 16'hFFFF);
        wb_write(6'h06, 2'b11, 16'hFFFF);
        wb_write(6'h08, 2'b11, 16'hFFFF);
        wb_write(6'h0A, 2'b11, 16'hFFFF);
        db_in = ~db_in;
        repeat (LAT + 2) @(negedge clk_i);
        check_eq("pre_rst_int", 32'(int_o), 32'd1);
        adr_i = 6'h0C; sel_i = 2'b11; we_i = 1'b0; stb_i = 1'b1; cyc_i = 1'b1;
        @(negedge clk_i);
        check_eq("mid_ack_hi", 32'(ack_o), 32'd1);
        #2 rst_n_i = 1'b0;
        #1;
        check_eq("mid_rst_ack", 32'(ack_o), 32'd0);
        check_eq("mid_rst_int", 32'(int_o), 32'd0);
        check_eq("mid_rst_dat", 32'(dat_o), 32'd0);
        stb_i = 1'b0; cyc_i = 1'b0;
        @(negedge clk_i);
        #2 rst_n_i = 1'b1;
        repeat (LAT + 3) @(negedge clk_i);
        wb_read(6'h0C, rd); check_eq("post_rst_ev", 32'(rd), 32'h0000);
        wb_read(6'h04, rd); check_eq("post_rst_ren", 32'(rd), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/db_status_capture16.md
Name: db_status_capture16

Overview:
- Receive-side companion to the daughterboard ATR control-line driver: samples 32 daughterboard status/readback lines back into the FPGA.
- Synchronizes and edge-detects those lines, latching masked rising/falling events into sticky flags.
- Exposes pins, masks, events and a snapshot over the same 16-bit Wishbone slave interface used by the control-line driver.
- Raises a level interrupt toward the settings/interrupt controller.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchronizer stages per input bit (allowed range 2..4).
- DEBOUNCE_CYCLES, 8, number of consecutive stable samples required before a change is accepted. Used only with the optional feature; allowed range 1..255.

Ports:
- clk_i  in  1  system clock; the single clock domain.
- rst_n_i  in  1  asynchronous, active-low reset.
- adr_i  in  6  byte address. adr_i[5:2] selects the register; adr_i[1] selects the half (1 = bits 31:16, 0 = bits 15:0).
- sel_i  in  2  byte selects within the 16-bit half.
- dat_i  in  16  write data.
- dat_o  out  16  read data; registered and valid in the cycle ack_o is high.
- we_i, stb_i, cyc_i  in  1 each  Wishbone write enable, strobe and cycle.
- ack_o  out  1  Wishbone acknowledge.
- db_in  in  32  asynchronous daughterboard status lines.
- int_o  out  1  interrupt, high while any event flag is set.

Behaviour:
- Reset (async assert, synchronous release): all synchronizer stages, pins, RISE_EN, FALL_EN, EVENTS and SNAP clear to 0; snap_valid clears to 0; ack_o = 0; dat_o = 0; int_o = 0.
- Ack: ack_o <= stb_i & cyc_i & ~ack_o. Every access takes 2 cycles; back-to-back strobes ack every other cycle. Writes and W1C take effect on the strobe cycle (first cycle of the access).
- Input path:
  - db_in -> SYNC_STAGES flops -> pins register.
  - prev holds pins delayed by one cycle.
  - rise = pins & ~prev; fall = ~pins & prev.
  - Latency from a db_in change to the event flag = SYNC_STAGES + 1 clocks.
- Register map (index = adr_i[5:2]):
  - 0 PINS: read-only; writes ignored.
  - 1 RISE_EN: read/write, byte-selectable.
  - 2 FALL_EN: read/write, byte-selectable.
  - 3 EVENTS: read; write-1-to-clear per selected byte.
  - 4 SNAP: read-only; the pins value captured when EVENTS goes from all-zero to nonzero.
  - 5-15: read 0; writes ignored.
- Byte-select mapping: with adr_i[1] = 1, sel_i[1] -> bits 31:24 and sel_i[0] -> bits 23:16; with adr_i[1] = 0, sel_i[1] -> bits 15:8 and sel_i[0] -> bits 7:0.
- Event update, per bit each cycle:
  - EVENTS_next = (EVENTS & ~clr) | (rise & RISE_EN) | (fall & FALL_EN).
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - A mask change takes effect on edges from the following cycle onward; it never creates events retroactively.
- SNAP: loaded with pins in the same cycle EVENTS_next becomes nonzero while EVENTS == 0. It holds until EVENTS returns to all-zero and a new first event arrives.
- int_o = |EVENTS, registered output.
- Reset mid-access: ack_o is dropped immediately and the transaction is lost. The master must retry.

Optional Feature:
- Macro: DB_STATUS_CAPTURE_DEBOUNCE_EN.
- Defined: a per-bit counter sits between the synchronizer and pins. pins[i] follows sync[i] only after sync[i] has differed from pins[i] for DEBOUNCE_CYCLES consecutive cycles; any revert resets the counter. Latency becomes SYNC_STAGES + DEBOUNCE_CYCLES + 1.
- Undefined: no counters; pins = synchronizer output.

Decomposition:
- Shared package holds:
  - register index constants DBSC_REG_PINS=0, RISE_EN=1, FALL_EN=2, EVENTS=3, SNAP=4;
  - the 32-bit line-width constant;
  - the ATR state encodings (IDLE=0, TX=1, RX=2, FULL_DUPLEX=3) shared with the control-line driver.
- One sub-module: db_sync_edge. It is per bit and contains the synchronizer, the optional debounce counter, and rise/fall outputs.

Test Plan:
- Reset, then read all registers -> every read returns 0x0000; int_o = 0; ack_o high exactly 1 cycle per access.
- RISE_EN = 0x0000_0001, db_in[0] 0->1 -> EVENTS = 0x0000_0001 after exactly 3 clocks (SYNC_STAGES=2); int_o = 1; SNAP low half = 0x0001.
- FALL_EN = 0x8000_0000, db_in[31] 1->0 with RISE_EN = 0 -> EVENTS hi half = 0x8000; a rising edge on bit 31 sets nothing.
- Write EVENTS with adr 0x0C, sel 2'b01, dat 0x0001 in the same cycle a new masked rise on bit 0 arrives -> bit 0 stays 1 (set wins).
- Write EVENTS with adr 0x0E, sel 2'b10, dat 0xFF00 -> only bits 31:24 clear; int_o falls once all bits are clear; the next event reloads SNAP.
- With DB_STATUS_CAPTURE_DEBOUNCE_EN and DEBOUNCE_CYCLES=8: a 5-cycle glitch on db_in[3] -> no event; a 20-cycle pulse -> one rise event at 2+8+1 = 11 clocks.
